rq_seq_num_tracker: RTL

RQ_SEQ_NUM_TRACKER -- requirements
Module: rq_seq_num_tracker

---
 rtl/rq_seq_pkg.sv | 27 ++
 rtl/rq_seq_lane_alloc.sv | 44 ++++
 rtl/rq_seq_num_tracker.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/rq_seq_pkg.sv
// Shared types and helpers for the RQ sequence-number tracker.
// Provides the sequence-number type, its maximum width and a wrap-aware adder
// that can skip the reserved value 0.
package rq_seq_pkg;

  localparam int unsigned RQ_SEQ_W_MAX = 8;

  typedef logic [RQ_SEQ_W_MAX-1:0] seq_num_t;

  // Adds offset to base within [skip_zero ? 1 : 0, 2**seq_w - 1].
  // Offsets never exceed the lane count (<= 4), which is always smaller than
  // the range size (>= 15), so a single corrective subtraction is enough.
  function automatic seq_num_t seq_wrap_add(input seq_num_t    base,
                                            input int unsigned offset,
                                            input int unsigned seq_w,
                                            input bit          skip_zero);
    int unsigned top;
    int unsigned sum;
    top = 32'd1 << seq_w;
    sum = 32'(base) + offset;
    if (sum >= top) begin
      sum = sum - top + (skip_zero ? 32'd1 : 32'd0);
    end
    return seq_num_t'(sum);
  endfunction

endpackage

// File: rtl/rq_seq_lane_alloc.sv
// Combinational candidate and grant generation for the assign lanes.
// Lane k is offered curr+k (wrapped); grants form a contiguous prefix and are
// only given for numbers currently available.
module rq_seq_lane_alloc
  import rq_seq_pkg::*;
#(
  parameter int unsigned NUM_ASN   = 2,
  parameter int unsigned SEQ_W     = 6,
  parameter int unsigned RSVD_ZERO = 1
) (
  input  logic [SEQ_W-1:0]         curr,
  input  logic [NUM_ASN-1:0]       asn_req,
  input  logic [2**SEQ_W-1:0]      avail,
  input  logic                     block,
  output logic [NUM_ASN-1:0]       asn_gnt,
  output logic [NUM_ASN*SEQ_W-1:0] asn_num,
  output logic [2:0]               gnt_cnt,
  output logic                     req_err
);

  logic             req_ok;
  logic             chain_ok;
  logic [SEQ_W-1:0] cand;

  // Candidate numbers, thermometer check and the grant prefix chain.
  always_comb begin
    asn_gnt  = '0;
    asn_num  = '0;
    gnt_cnt  = '0;
    cand     = '0;
    // A thermometer code has no set bit above a clear bit: x & (x+1) == 0.
    req_ok   = (asn_req & (asn_req + NUM_ASN'(1))) == '0;
    chain_ok = req_ok && !block;
    for (int unsigned k = 0; k < NUM_ASN; k++) begin
      cand = SEQ_W'(seq_wrap_add(seq_num_t'(curr), k, SEQ_W, RSVD_ZERO != 0));
      asn_num[k*SEQ_W +: SEQ_W] = cand;
      asn_gnt[k] = asn_req[k] && avail[cand] && chain_ok;
      chain_ok   = asn_gnt[k];
      gnt_cnt    = gnt_cnt + 3'(asn_gnt[k]);
    end
    req_err = !req_ok;
  end

endmodule

// File: rtl/rq_seq_num_tracker.sv
// RQ sequence-number tracker: hands out sequence numbers on up to NUM_ASN
// lanes per cycle, takes them back on NUM_REL release ports, and flags
// protocol errors. Optional stall watchdog under SEQ_TRK_WATCHDOG_EN.
module rq_seq_num_tracker
  import rq_seq_pkg::*;
#(
  parameter int unsigned NUM_ASN   = 2,
  parameter int unsigned NUM_REL   = 2,
  parameter int unsigned SEQ_W     = 6,
  parameter int unsigned RSVD_ZERO = 1,
  parameter int unsigned WD_CYC    = 4096
) (
  input  logic                     user_clk,
  input  logic                     reset_n,
  input  logic                     init_rst_i,
  input  logic [NUM_ASN-1:0]       asn_req,
  output logic [NUM_ASN-1:0]       asn_gnt,
  output logic [NUM_ASN*SEQ_W-1:0] asn_num,
  input  logic [NUM_REL-1:0]       rel_vld,
  input  logic [NUM_REL*SEQ_W-1:0] rel_num,
  output logic [2**SEQ_W-1:0]      avail,
  output logic [SEQ_W:0]           outstanding,
  output logic                     all_back,
  output logic                     err_rel,
  output logic                     err_req,
  output logic                     wd_timeout
);

  localparam int unsigned NUM_SEQ = 2**SEQ_W;
  localparam logic [SEQ_W-1:0] CURR_RST = (RSVD_ZERO != 0) ? SEQ_W'(1) : '0;

  if (NUM_ASN < 1 || NUM_ASN > 4 || NUM_REL < 1 || NUM_REL > 4 ||
      SEQ_W < 4 || SEQ_W > RQ_SEQ_W_MAX || WD_CYC < 1) begin : g_param_chk
    $error("rq_seq_num_tracker: parameter out of range");
  end

  logic [SEQ_W-1:0]   curr_q, curr_d;
  logic [NUM_SEQ-1:0] avail_q, avail_d;
  logic [SEQ_W:0]     outst_q, outst_d;
  logic               err_rel_q, err_rel_d;
  logic               err_req_q, err_req_d;

  logic               block;
  logic [2:0]         gnt_cnt;
  logic               req_err;
  logic [NUM_SEQ-1:0] gnt_mask;
  logic [NUM_SEQ-1:0] rel_mask;
  logic [2:0]         rel_cnt;
  logic               rel_err;
  logic [SEQ_W-1:0]   rel_idx;

  assign block = !reset_n || init_rst_i;

  rq_seq_lane_alloc #(
    .NUM_ASN   (NUM_ASN),
    .SEQ_W     (SEQ_W),
    .RSVD_ZERO (RSVD_ZERO)
  ) u_lane_alloc (
    .curr    (curr_q),
    .asn_req (asn_req),
    .avail   (avail_q),
    .block   (block),
    .asn_gnt (asn_gnt),
    .asn_num (asn_num),
    .gnt_cnt (gnt_cnt),
    .req_err (req_err)
  );

  // Numbers granted this cycle.
  always_comb begin
    gnt_mask = '0;
    for (int unsigned k = 0; k < NUM_ASN; k++) begin
      if (asn_gnt[k]) gnt_mask[asn_num[k*SEQ_W +: SEQ_W]] = 1'b1;
    end
  end

  // Accept releases of outstanding numbers once; anything else is an error.
  // A grant only ever takes an available number, so a release colliding with a
  // same-cycle grant is already caught by the availability test.
  always_comb begin
    rel_mask = '0;
    rel_cnt  = '0;
    rel_err  = 1'b0;
    rel_idx  = '0;
    for (int unsigned p = 0; p < NUM_REL; p++) begin
      rel_idx = rel_num[p*SEQ_W +: SEQ_W];
      if (rel_vld[p]) begin
        if (avail_q[rel_idx] || rel_mask[rel_idx]) begin
          rel_err = 1'b1;
        end else begin
          rel_mask[rel_idx] = 1'b1;
          rel_cnt           = rel_cnt + 3'd1;
        end
      end
    end
  end

  // Next-state for pointer, availability, count and sticky flags.
  always_comb begin
    curr_d  = SEQ_W'(seq_wrap_add(seq_num_t'(curr_q), 32'(gnt_cnt), SEQ_W, RSVD_ZERO != 0));
    avail_d = (avail_q | rel_mask) & ~gnt_mask;
    if (RSVD_ZERO != 0) avail_d[0] = 1'b1;
    outst_d   = outst_q + (SEQ_W+1)'(gnt_cnt) - (SEQ_W+1)'(rel_cnt);
    err_rel_d = err_rel_q || rel_err;
    err_req_d = err_req_q || req_err;
  end

  // State registers; hard reset and soft reinit both restore reset values.
  always_ff @(posedge user_clk) begin
    if (!reset_n || init_rst_i) begin
      curr_q    <= CURR_RST;
      avail_q   <= '1;
      outst_q   <= '0;
      err_rel_q <= 1'b0;
      err_req_q <= 1'b0;
    end else begin
      curr_q    <= curr_d;
      avail_q   <= avail_d;
      outst_q   <= outst_d;
      err_rel_q <= err_rel_d;
      err_req_q <= err_req_d;
    end
  end

`ifdef SEQ_TRK_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYC + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_to_q, wd_to_d;

  // Count cycles with work outstanding but no accepted release; saturate.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_to_d  = wd_to_q;
    if (rel_cnt != 3'd0 || outst_q == '0) begin
      wd_cnt_d = '0;
    end else if (wd_cnt_q != WD_W'(WD_CYC)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (wd_cnt_d == WD_W'(WD_CYC)) wd_to_d = 1'b1;
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge user_clk) begin
    if (!reset_n || init_rst_i) begin
      wd_cnt_q <= '0;
      wd_to_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_to_q  <= wd_to_d;
    end
  end

  assign wd_timeout = wd_to_q;
`else
  assign wd_timeout = 1'b0;
`endif

  assign avail       = avail_q;
  assign outstanding = outst_q;
  assign all_back    = (outst_q == '0);
  assign err_rel     = err_rel_q;
  assign err_req     = err_req_q;

endmodule
